change_dispenser: RTL and testbench
===================================

# change_dispenser

Output stage directly downstream of the vending controller. It consumes the controller's one-cycle `soda` vend pulse and its 3-bit `change` code, which counts nickels owed (0–4). For each vend it releases one soda, then pays the change one nickel at a time through a four-phase handshake with the coin hopper. Vend events are queued in a small FIFO, so back-to-back purchases are never lost while the hopper is slow. A missing hopper acknowledge is latched as a fault.

## Interface
- `FIFO_DEPTH`, default 2: number of pending vend events held. Power of two, minimum 2.
- `ACK_TIMEOUT`, default 255: cycles allowed for each hopper ack edge before fault. Range 1–65535.
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `soda` in 1: vend pulse from controller; one event per high cycle.
- `change` in 3: nickels owed, sampled when `soda`=1. Values 5–7 saturate to 4.
- `hopper_ack` in 1: hopper acknowledge (level).
- `hopper_req` out 1: nickel request to hopper (level).
- `soda_rel` out 1: one-cycle soda release strobe.
- `busy` out 1: high when FIFO is non-empty or FSM is not IDLE.
- `overflow` out 1: sticky; a vend arrived while the FIFO was full.
- `fault` out 1: sticky; hopper timeout occurred.
- `nickels_out` out 8: total nickels paid, wrapping (see Configuration).

## Operation
- **FIFO.** Entries are 3-bit saturated change values.
  - Push when `soda`=1.
  - Pop when the FSM leaves IDLE.
  - Push and pop in the same cycle while full: both succeed; the count is unchanged.
  - Push while full without a pop: the event is dropped and `overflow` is set.
- **FSM states:** IDLE, RELEASE, REQ, ACKLO, FAULT.
  - **IDLE:** if the FIFO is non-empty, pop into `remain` and go to RELEASE.
  - **RELEASE:** `soda_rel`=1 for exactly this cycle.
    - `remain`=0 → IDLE.
    - Otherwise → REQ.
  - **REQ:** `hopper_req`=1 and the timer counts.
    - `hopper_ack`=1 → drop `hopper_req`, decrement `remain`, increment `nickels_out`, clear the timer, go to ACKLO.
    - Timer reaches `ACK_TIMEOUT` → FAULT.
  - **ACKLO:** `hopper_req`=0 and the timer counts.
    - `hopper_ack`=0 → clear the timer. Go to REQ if `remain`≠0, else IDLE.
    - Timer reaches `ACK_TIMEOUT` → FAULT.
  - **FAULT:** terminal until reset.
    - `hopper_req`=0 and `soda_rel`=0.
    - The FIFO still accepts pushes and sets `overflow` when full, but never pops.
- **Timer:** 16 bits, saturating, and cleared on every state entry.
- **Reset (`reset_n`=0 at a rising edge), including mid-payment:**
  - FSM → IDLE; FIFO emptied; `remain`, timer, `overflow`, `fault` and `nickels_out` cleared.
  - All outputs read 0 in the following cycle.
  - A `soda` pulse coincident with reset is discarded.

## Timing
- All outputs are registered.
- Vend latency from an empty FIFO and IDLE: `soda` high in cycle N → push at edge N → IDLE pop at edge N+1 → `soda_rel` high in cycle N+2.
- The first `hopper_req` rises in cycle N+3.
- `hopper_req` falls in the cycle after `hopper_ack` is sampled high.
- The next `hopper_req` rises in the cycle after `hopper_ack` is sampled low.
- After completing a vend, the FSM returns to IDLE and can take the next FIFO entry one cycle later. Back-to-back `soda_rel` strobes are therefore at least 2 cycles apart.
- `busy` is high from the cycle after a push until the cycle after the FSM returns to IDLE with an empty FIFO.

## Configuration
- **`CHANGE_DISPENSER_COUNT_EN` defined:** `nickels_out` is an 8-bit register, +1 per acknowledged nickel, wraps 255→0, reset to 0.
- **Not defined:** no counter is instantiated and `nickels_out` is tied to 8'd0. All other behaviour is identical.

## Test plan
- **Single vend, exact payment.** Reset, then `soda`=1 with `change`=0 for one cycle.
  - Required: `soda_rel` pulses once in cycle +2.
  - Required: `hopper_req` never rises; `busy` falls; `nickels_out`=0.
- **Change of 3.** `soda` with `change`=3; hopper acks 2 cycles after each req rise and drops ack 2 cycles after req falls.
  - Required: exactly 3 req/ack handshakes.
  - Required: `nickels_out`=3 (with `_EN`); FSM ends in IDLE.
- **Queued vends and overflow.** `FIFO_DEPTH`=2. While the first vend's payment is stalled (ack held low), issue 3 additional `soda` pulses with `change`=1, 2, 4.
  - Required: `overflow` is set on the third pulse.
  - Required: after releasing ack, the releases/payments are 1, 2 nickels; the third (4-nickel) event is lost.
- **Saturation.** `change`=7 → exactly 4 nickels dispensed.
- **Timeout.** `ACK_TIMEOUT`=10; `hopper_ack` held at 0 after a req.
  - Required: `fault`=1 after 10 REQ cycles; `hopper_req`=0.
  - Required: further `soda` pulses produce no `soda_rel`.
- **Reset mid-payment.** Assert `reset_n`=0 during ACKLO of the second of 4 nickels.
  - Required: next cycle all outputs are 0 and the FIFO is empty.
  - Required: a new vend with `change`=1 then completes normally.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser
//   Output stage behind the vending controller. Each soda vend pulse queues its
//   (saturated) change code in a small FIFO. The FSM then strobes the soda
//   release and pays the change one nickel at a time over a four-phase
//   req/ack handshake with the coin hopper. A hopper edge that does not arrive
//   within ACK_TIMEOUT cycles latches a terminal fault.
//
//   Parameters
//     FIFO_DEPTH  : pending vend events held (power of two, >= 2)
//     ACK_TIMEOUT : cycles allowed per hopper ack edge (1..65535)
//
//   Ports
//     clk         : clock, rising edge
//     reset_n     : synchronous active-low reset
//     soda        : vend pulse, one event per high cycle
//     change      : nickels owed (0..4, 5..7 saturate to 4), sampled with soda
//     hopper_ack  : hopper acknowledge level
//     hopper_req  : nickel request level to hopper
//     soda_rel    : one-cycle soda release strobe
//     busy        : FIFO non-empty or FSM not idle
//     overflow    : sticky, vend dropped because FIFO was full
//     fault       : sticky, hopper handshake timed out
//     nickels_out : wrapping count of nickels paid
//
//   Build option
//     CHANGE_DISPENSER_COUNT_EN : when defined, nickels_out is a live 8-bit
//                                 counter; otherwise it is tied to zero.

module change_dispenser #(
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       soda,
    input  logic [2:0] change,
    input  logic       hopper_ack,
    output logic       hopper_req,
    output logic       soda_rel,
    output logic       busy,
    output logic       overflow,
    output logic       fault,
    output logic [7:0] nickels_out
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    // Timer value seen in the last allowed waiting cycle
    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELEASE,
        S_REQ,
        S_ACKLO,
        S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      remain_q, remain_d;
    logic [15:0]     timer_q, timer_d;
    logic            hopper_req_q, hopper_req_d;
    logic            soda_rel_q, soda_rel_d;
    logic            busy_q, busy_d;
    logic            overflow_q, overflow_d;
    logic            fault_q, fault_d;
`ifdef CHANGE_DISPENSER_COUNT_EN
    logic [7:0]      nick_q, nick_d;
`endif

    logic [2:0]      sat_change;
    logic            fifo_full;
    logic            pop;
    logic            push_ok;

    always_comb begin
        sat_change = (change > 3'd4) ? 3'd4 : change;
        fifo_full  = (count_q == FULL_CNT);
        pop        = (state_q == S_IDLE) && (count_q != '0);
        // A pop in the same cycle frees a slot, so a full FIFO still accepts
        push_ok    = soda && (!fifo_full || pop);

        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | (soda & fifo_full & ~pop);

        state_d      = state_q;
        remain_d     = remain_q;
        hopper_req_d = hopper_req_q;
        soda_rel_d   = 1'b0;
        fault_d      = fault_q;
`ifdef CHANGE_DISPENSER_COUNT_EN
        nick_d       = nick_q;
`endif
        timer_d      = timer_q;
        if ((state_q == S_REQ || state_q == S_ACKLO) && timer_q != '1) begin
            timer_d = timer_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    remain_d   = mem_q[rd_ptr_q];
                    state_d    = S_RELEASE;
                    soda_rel_d = 1'b1;
                    timer_d    = '0;
                end
            end
            S_RELEASE: begin
                timer_d = '0;
                if (remain_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d      = S_REQ;
                    hopper_req_d = 1'b1;
                end
            end
            S_REQ: begin
                if (hopper_ack) begin
                    hopper_req_d = 1'b0;
                    remain_d     = remain_q - 3'd1;
`ifdef CHANGE_DISPENSER_COUNT_EN
                    nick_d       = nick_q + 8'd1;
`endif
                    timer_d      = '0;
                    state_d      = S_ACKLO;
                end else if (timer_q >= TO_LAST) begin
                    hopper_req_d = 1'b0;
                    fault_d      = 1'b1;
                    timer_d      = '0;
                    state_d      = S_FAULT;
                end
            end
            S_ACKLO: begin
                if (!hopper_ack) begin
                    timer_d = '0;
                    if (remain_q != 3'd0) begin
                        state_d      = S_REQ;
                        hopper_req_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (timer_q >= TO_LAST) begin
                    fault_d = 1'b1;
                    timer_d = '0;
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                hopper_req_d = 1'b0;
                timer_d      = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (count_d != '0) || (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            remain_q     <= '0;
            timer_q      <= '0;
            hopper_req_q <= 1'b0;
            soda_rel_q   <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            fault_q      <= 1'b0;
`ifdef CHANGE_DISPENSER_COUNT_EN
            nick_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            remain_q     <= remain_d;
            timer_q      <= timer_d;
            hopper_req_q <= hopper_req_d;
            soda_rel_q   <= soda_rel_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            fault_q      <= fault_d;
`ifdef CHANGE_DISPENSER_COUNT_EN
            nick_q       <= nick_d;
`endif
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (reset_n && push_ok) begin
            mem_q[wr_ptr_q] <= sat_change;
        end
    end

    assign hopper_req = hopper_req_q;
    assign soda_rel   = soda_rel_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign fault      = fault_q;
`ifdef CHANGE_DISPENSER_COUNT_EN
    assign nickels_out = nick_q;
`else
    assign nickels_out = '0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
//   Directed bench for change_dispenser (FIFO_DEPTH=2, ACK_TIMEOUT=10).
//   A simple hopper responder raises ack two cycles after req rises and drops
//   it two cycles after req falls, when enabled.

module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       soda;
    logic [2:0] change;
    logic       hopper_ack;
    logic       hopper_req;
    logic       soda_rel;
    logic       busy;
    logic       overflow;
    logic       fault;
    logic [7:0] nickels_out;

    int checks = 0;
    int errors = 0;
    int rel_cnt = 0;
    int req_rises = 0;
    logic prev_req = 1'b0;
    logic hop_en = 1'b0;
    int age = 0;

    change_dispenser #(
        .FIFO_DEPTH (2),
        .ACK_TIMEOUT(10)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .soda       (soda),
        .change     (change),
        .hopper_ack (hopper_ack),
        .hopper_req (hopper_req),
        .soda_rel   (soda_rel),
        .busy       (busy),
        .overflow   (overflow),
        .fault      (fault),
        .nickels_out(nickels_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_nick(input int n);
`ifdef CHANGE_DISPENSER_COUNT_EN
        return 32'(n % 256);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample outputs 1 time unit after the edge, then let the
    // hopper responder update its ack for the rest of the cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (soda_rel) rel_cnt++;
        if (hopper_req && !prev_req) req_rises++;
        prev_req = hopper_req;
        if (hop_en) begin
            if (hopper_req && !hopper_ack) begin
                age++;
                if (age >= 2) begin hopper_ack = 1'b1; age = 0; end
            end else if (!hopper_req && hopper_ack) begin
                age++;
                if (age >= 2) begin hopper_ack = 1'b0; age = 0; end
            end else begin
                age = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        soda       = 1'b0;
        change     = 3'd0;
        hopper_ack = 1'b0;
        age        = 0;
        tick();
        tick();
        reset_n   = 1'b1;
        rel_cnt   = 0;
        req_rises = 0;
    endtask

    task automatic vend(input logic [2:0] c);
        soda   = 1'b1;
        change = c;
        tick();
        soda = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) tick();
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        soda       = 1'b0;
        change     = 3'd0;
        hopper_ack = 1'b0;

        // Reset state
        do_reset();
        check("rst_req",  {31'd0, hopper_req}, 32'd0);
        check("rst_rel",  {31'd0, soda_rel},   32'd0);
        check("rst_busy", {31'd0, busy},       32'd0);
        check("rst_ovf",  {31'd0, overflow},   32'd0);
        check("rst_flt",  {31'd0, fault},      32'd0);
        check("rst_nick", {24'd0, nickels_out}, 32'd0);

        // Single vend, exact payment
        hop_en = 1'b1;
        vend(3'd0);                                          // now in N+1
        check("ex_rel_n1",  {31'd0, soda_rel}, 32'd0);
        check("ex_busy_n1", {31'd0, busy},     32'd1);
        tick();                                              // N+2
        check("ex_rel_n2",  {31'd0, soda_rel}, 32'd1);
        tick();                                              // N+3
        check("ex_rel_n3",  {31'd0, soda_rel}, 32'd0);
        check("ex_busy_n3", {31'd0, busy},     32'd0);
        tick(); tick(); tick();
        check("ex_rises",   32'(req_rises), 32'd0);
        check("ex_rels",    32'(rel_cnt),   32'd1);
        check("ex_nick",    {24'd0, nickels_out}, 32'd0);

        // Change of 3
        do_reset();
        vend(3'd3);
        tick();                                              // N+2
        check("c3_rel",     {31'd0, soda_rel},   32'd1);
        tick();                                              // N+3
        check("c3_req_n3",  {31'd0, hopper_req}, 32'd1);
        wait_idle("c3_idle");
        tick(); tick();
        check("c3_rises",   32'(req_rises), 32'd3);
        check("c3_rels",    32'(rel_cnt),   32'd1);
        check("c3_nick",    {24'd0, nickels_out}, exp_nick(3));
        check("c3_req_end", {31'd0, hopper_req}, 32'd0);

        // Saturation: change 7 pays 4
        do_reset();
        vend(3'd7);
        wait_idle("sat_idle");
        tick(); tick();
        check("sat_rises", 32'(req_rises), 32'd4);
        check("sat_nick",  {24'd0, nickels_out}, exp_nick(4));

        // Queued vends and overflow: stall first payment, push 1, 2, 4
        do_reset();
        hop_en = 1'b0;
        vend(3'd1);                                          // N+1
        tick();                                              // N+2
        tick();                                              // N+3
        check("q_req_n3", {31'd0, hopper_req}, 32'd1);
        soda = 1'b1; change = 3'd1; tick();                  // N+4
        change = 3'd2; tick();                               // N+5
        check("q_ovf_full", {31'd0, overflow}, 32'd0);
        change = 3'd4; tick();                               // N+6
        soda = 1'b0;
        check("q_ovf_set",  {31'd0, overflow}, 32'd1);
        hop_en = 1'b1;
        wait_idle("q_idle");
        tick(); tick();
        check("q_rels",  32'(rel_cnt),   32'd3);
        check("q_rises", 32'(req_rises), 32'd4);
        check("q_ovf",   {31'd0, overflow}, 32'd1);
        check("q_flt",   {31'd0, fault},    32'd0);
        check("q_nick",  {24'd0, nickels_out}, exp_nick(4));

        // Reset during ACKLO of the second of 4 nickels, with one vend queued
        do_reset();
        vend(3'd4);
        vend(3'd2);
        for (int i = 0; i < 100 && !(req_rises == 2 && !hopper_req && hopper_ack); i++) tick();
        check("mr_in_acklo", {31'd0, (req_rises == 2 && !hopper_req && hopper_ack)}, 32'd1);
        check("mr_busy_pre", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        soda    = 1'b1;
        change  = 3'd3;
        tick();
        reset_n = 1'b1;
        soda    = 1'b0;
        check("mr_req",  {31'd0, hopper_req}, 32'd0);
        check("mr_rel",  {31'd0, soda_rel},   32'd0);
        check("mr_busy", {31'd0, busy},       32'd0);
        check("mr_ovf",  {31'd0, overflow},   32'd0);
        check("mr_flt",  {31'd0, fault},      32'd0);
        check("mr_nick", {24'd0, nickels_out}, 32'd0);
        rel_cnt   = 0;
        req_rises = 0;
        for (int i = 0; i < 6; i++) tick();
        check("mr_empty_rel",  32'(rel_cnt), 32'd0);
        check("mr_empty_busy", {31'd0, busy}, 32'd0);
        vend(3'd1);
        wait_idle("mr_idle");
        tick(); tick();
        check("mr_new_rels",  32'(rel_cnt),   32'd1);
        check("mr_new_rises", 32'(req_rises), 32'd1);
        check("mr_new_nick",  {24'd0, nickels_out}, exp_nick(1));

        // Timeout: ack never arrives
        do_reset();
        hop_en = 1'b0;
        vend(3'd2);                                          // N+1
        tick();                                              // N+2
        tick();                                              // N+3, REQ 1st cycle
        check("to_req_n3", {31'd0, hopper_req}, 32'd1);
        for (int i = 0; i < 9; i++) tick();                  // N+12, REQ 10th cycle
        check("to_flt_n12", {31'd0, fault},      32'd0);
        check("to_req_n12", {31'd0, hopper_req}, 32'd1);
        tick();                                              // N+13
        check("to_flt",  {31'd0, fault},      32'd1);
        check("to_req",  {31'd0, hopper_req}, 32'd0);
        soda = 1'b1; change = 3'd1;
        tick(); tick(); tick();
        soda = 1'b0;
        tick(); tick(); tick();
        check("to_rels",  32'(rel_cnt),   32'd1);
        check("to_rises", 32'(req_rises), 32'd1);
        check("to_ovf",   {31'd0, overflow},   32'd1);
        check("to_busy",  {31'd0, busy},       32'd1);
        check("to_req2",  {31'd0, hopper_req}, 32'd0);
        check("to_nick",  {24'd0, nickels_out}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
